pcpu_fetch: RTL and testbench

//  Instruction-fetch (IF) stage of the 16-bit pipelined pcpu. Drives the 8-bit

---
 rtl/pcpu_defs.sv | 31 +++
 rtl/pcpu_fetch_perf.sv | 42 ++++
 rtl/pcpu_fetch.sv | 129 ++++++++++++
 tb/tb_pcpu_fetch.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pcpu_defs.sv
// Shared definitions for the pcpu pipeline: opcodes, the NOP word, fetch FSM
// state encodings and default address/instruction widths.
package pcpu_defs;

  localparam int AW_DEF = 8;
  localparam int IW_DEF = 16;

  localparam logic [4:0] OP_NOP   = 5'b00000;
  localparam logic [4:0] OP_HALT  = 5'b00001;
  localparam logic [4:0] OP_LOAD  = 5'b00010;
  localparam logic [4:0] OP_STORE = 5'b00011;
  localparam logic [4:0] OP_JUMP  = 5'b11000;
  localparam logic [4:0] OP_JMPR  = 5'b11001;
  localparam logic [4:0] OP_BZ    = 5'b11010;
  localparam logic [4:0] OP_BNZ   = 5'b11011;
  localparam logic [4:0] OP_BN    = 5'b11100;
  localparam logic [4:0] OP_BNN   = 5'b11101;
  localparam logic [4:0] OP_BC    = 5'b11110;
  localparam logic [4:0] OP_BNC   = 5'b11111;

  localparam logic [15:0] NOP_WORD = 16'h0000;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  function automatic logic is_halt(input logic [4:0] opcode);
    return opcode == OP_HALT;
  endfunction

endpackage

// File: rtl/pcpu_fetch_perf.sv
// Saturating fetch/bubble event counters for the pcpu fetch stage (FETCH_PERF_EN builds only).
module pcpu_fetch_perf (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        fetch_inc_i,
  input  logic        bubble_inc_i,
  output logic [15:0] fetch_cnt_o,
  output logic [15:0] bubble_cnt_o
);

  logic [15:0] fetch_q, fetch_d;
  logic [15:0] bubble_q, bubble_d;

  always_comb begin
    fetch_d  = fetch_q;
    bubble_d = bubble_q;
    if (clear_i) begin
      fetch_d  = '0;
      bubble_d = '0;
    end else begin
      if (fetch_inc_i && fetch_q != 16'hFFFF)
        fetch_d = fetch_q + 16'd1;
      if (bubble_inc_i && bubble_q != 16'hFFFF)
        bubble_d = bubble_q + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_q  <= '0;
      bubble_q <= '0;
    end else begin
      fetch_q  <= fetch_d;
      bubble_q <= bubble_d;
    end
  end

  assign fetch_cnt_o  = fetch_q;
  assign bubble_cnt_o = bubble_q;

endmodule

// File: rtl/pcpu_fetch.sv
// pcpu instruction-fetch stage: PC, IF/ID register and IDLE/EXEC/HALT run control.
// Optional FETCH_PERF_EN adds fetch_cnt/bubble_cnt performance counter ports.
module pcpu_fetch
  import pcpu_defs::*;
#(
  parameter int            AW     = AW_DEF,
  parameter int            IW     = IW_DEF,
  parameter logic [AW-1:0] RST_PC = '0
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable,
  input  logic          start,
  output logic [AW-1:0] i_addr,
  input  logic [IW-1:0] i_datain,
  input  logic          stall,
  input  logic          branch_taken,
  input  logic [AW-1:0] branch_addr,
  output logic [IW-1:0] id_ir,
  output logic [AW-1:0] id_pc,
  output logic          running,
  output logic          halted
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]   fetch_cnt,
  output logic [15:0]   bubble_cnt
`endif
);

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [IW-1:0] ir_q, ir_d;
  logic [AW-1:0] idpc_q, idpc_d;

  // NOTE: every next-state signal gets a hold default first so no path through
  // the case leaves it unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    idpc_d  = idpc_q;
    case (state_q)
      ST_IDLE: begin
        ir_d = IW'(NOP_WORD);
        if (enable && start) begin
          state_d = ST_EXEC;
          pc_d    = RST_PC;
        end
      end
      ST_EXEC: begin
        if (!enable) begin
          state_d = ST_IDLE;
          ir_d    = IW'(NOP_WORD);
        end else if (branch_taken) begin
          pc_d = branch_addr;
          ir_d = IW'(NOP_WORD);
        end else if (!stall) begin
          ir_d   = i_datain;
          idpc_d = pc_q;
          // A fetched HALT freezes the PC on its own address.
          if (is_halt(i_datain[IW-1 -: 5]))
            state_d = ST_HALT;
          else
            pc_d = pc_q + AW'(1);
        end
      end
      ST_HALT: begin
        if (!enable) begin
          state_d = ST_IDLE;
          ir_d    = IW'(NOP_WORD);
        end else if (branch_taken) begin
          state_d = ST_EXEC;
          pc_d    = branch_addr;
          ir_d    = IW'(NOP_WORD);
        end else if (!stall) begin
          ir_d = IW'(NOP_WORD);
        end
      end
      default: begin
        state_d = ST_IDLE;
        ir_d    = IW'(NOP_WORD);
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update from the same pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      pc_q    <= RST_PC;
      ir_q    <= IW'(NOP_WORD);
      idpc_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      idpc_q  <= idpc_d;
    end
  end

  assign i_addr  = pc_q;
  assign id_ir   = ir_q;
  assign id_pc   = idpc_q;
  assign running = (state_q == ST_EXEC);
  assign halted  = (state_q == ST_HALT);

`ifdef FETCH_PERF_EN
  logic perf_clear, perf_fetch, perf_bubble;

  always_comb begin
    perf_clear  = (state_q == ST_IDLE) && enable && start;
    perf_fetch  = (state_q == ST_EXEC) && enable && !branch_taken && !stall;
    perf_bubble = ((state_q == ST_EXEC) || (state_q == ST_HALT)) && enable &&
                  (stall || branch_taken);
  end

  pcpu_fetch_perf u_perf (
    .clock        (clock),
    .reset        (reset),
    .clear_i      (perf_clear),
    .fetch_inc_i  (perf_fetch),
    .bubble_inc_i (perf_bubble),
    .fetch_cnt_o  (fetch_cnt),
    .bubble_cnt_o (bubble_cnt)
  );
`endif

endmodule

// File: tb/tb_pcpu_fetch.sv
// Directed bench for pcpu_fetch: cycle-level behavioural model checked every
// negedge, plus hand-computed expectations at key points of each scenario.
module tb_pcpu_fetch;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable, start, stall, branch_taken;
  logic [7:0]  branch_addr;
  logic [7:0]  i_addr;
  logic [15:0] i_datain;
  logic [15:0] id_ir;
  logic [7:0]  id_pc;
  logic        running, halted;
`ifdef FETCH_PERF_EN
  logic [15:0] fetch_cnt, bubble_cnt;
`endif

  logic [15:0] mem [256];
  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  assign i_datain = mem[i_addr];

  pcpu_fetch dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .start        (start),
    .i_addr       (i_addr),
    .i_datain     (i_datain),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .id_ir        (id_ir),
    .id_pc        (id_pc),
    .running      (running),
    .halted       (halted)
`ifdef FETCH_PERF_EN
    ,
    .fetch_cnt    (fetch_cnt),
    .bubble_cnt   (bubble_cnt)
`endif
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Behavioural model: run mode plus the architectural PC and IF/ID contents.
  typedef enum {M_IDLE, M_EXEC, M_HALT} mode_t;
  mode_t       m_mode;
  logic [7:0]  m_pc, m_idpc;
  logic [15:0] m_ir;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_mode <= M_IDLE;
      m_pc   <= 8'h00;
      m_ir   <= 16'h0000;
      m_idpc <= 8'h00;
    end else if (m_mode == M_IDLE) begin
      m_ir <= 16'h0000;
      if (enable && start) begin
        m_mode <= M_EXEC;
        m_pc   <= 8'h00;
      end
    end else if (!enable) begin
      m_mode <= M_IDLE;
      m_ir   <= 16'h0000;
    end else if (branch_taken) begin
      m_mode <= M_EXEC;
      m_pc   <= branch_addr;
      m_ir   <= 16'h0000;
    end else if (stall) begin
      // everything held
    end else if (m_mode == M_HALT) begin
      m_ir <= 16'h0000;
    end else begin
      m_ir   <= mem[m_pc];
      m_idpc <= m_pc;
      if (mem[m_pc][15:11] == 5'b00001)
        m_mode <= M_HALT;
      else
        m_pc <= m_pc + 8'd1;
    end
  end

  always @(negedge clock) begin
    check("cmp_i_addr", {24'h0, i_addr}, {24'h0, m_pc});
    check("cmp_id_ir", {16'h0, id_ir}, {16'h0, m_ir});
    check("cmp_id_pc", {24'h0, id_pc}, {24'h0, m_idpc});
    check("cmp_running", {31'h0, running}, {31'h0, (m_mode == M_EXEC)});
    check("cmp_halted", {31'h0, halted}, {31'h0, (m_mode == M_HALT)});
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h7000 + 16'(i * 17);
    mem[18] = 16'h0800;
    reset = 1'b0; enable = 1'b0; start = 1'b0; stall = 1'b0;
    branch_taken = 1'b0; branch_addr = 8'h00;

    tick(2);
    check("rst_addr", {24'h0, i_addr}, 32'h0);
    check("rst_ir", {16'h0, id_ir}, 32'h0);
    check("rst_run_halt", {30'h0, running, halted}, 32'h0);
    reset = 1'b1;

    // short run, then reset mid-operation
    enable = 1'b1; start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(4);
    reset = 1'b0;
    #1;
    check("midrst_addr", {24'h0, i_addr}, 32'h0);
    check("midrst_ir", {16'h0, id_ir}, 32'h0);
    check("midrst_running", {31'h0, running}, 32'h0);
    tick(1);
    reset = 1'b1;
    tick(1);

    // 1: start and sequential fetch
    start = 1'b1;
    tick(1);
    check("t1_addr0", {24'h0, i_addr}, 32'h0);
    check("t1_running", {31'h0, running}, 32'h1);
    start = 1'b0;
    tick(1);
    check("t1_addr1", {24'h0, i_addr}, 32'h1);
    check("t1_ir0", {16'h0, id_ir}, 32'h7000);
    check("t1_pc0", {24'h0, id_pc}, 32'h0);
    tick(1);
    check("t1_addr2", {24'h0, i_addr}, 32'h2);
    check("t1_ir1", {16'h0, id_ir}, 32'h7011);
    check("t1_pc1", {24'h0, id_pc}, 32'h1);

    // 2: stall at pc=5
    tick(3);
    stall = 1'b1;
    tick(2);
    check("t2_addr", {24'h0, i_addr}, 32'h5);
    check("t2_ir", {16'h0, id_ir}, 32'h7044);
    check("t2_pc", {24'h0, id_pc}, 32'h4);
    stall = 1'b0;
    tick(1);
    check("t2_ir_rel", {16'h0, id_ir}, 32'h7055);
    check("t2_addr_rel", {24'h0, i_addr}, 32'h6);

    // 3: branch beats stall at pc=8
    tick(2);
    check("t3_addr8", {24'h0, i_addr}, 32'h8);
    branch_taken = 1'b1; branch_addr = 8'h0b; stall = 1'b1;
    tick(1);
    check("t3_addr", {24'h0, i_addr}, 32'h0b);
    check("t3_flush", {16'h0, id_ir}, 32'h0);
    check("t3_idpc", {24'h0, id_pc}, 32'h7);
    branch_taken = 1'b0; stall = 1'b0;
    tick(1);
    check("t3_ir", {16'h0, id_ir}, 32'h70bb);

    // 4: HALT at 18, stall in HALT, resume by branch
    tick(6);
    check("t4_ir17", {16'h0, id_ir}, 32'h7121);
    tick(1);
    check("t4_halt_ir", {16'h0, id_ir}, 32'h0800);
    check("t4_halted", {30'h0, running, halted}, 32'h1);
    check("t4_addr", {24'h0, i_addr}, 32'd18);
    stall = 1'b1;
    tick(1);
    check("t4_stall_hold", {16'h0, id_ir}, 32'h0800);
    stall = 1'b0;
    tick(2);
    check("t4_nop", {16'h0, id_ir}, 32'h0);
    check("t4_addr_hold", {24'h0, i_addr}, 32'd18);
    branch_taken = 1'b1; branch_addr = 8'h01;
    tick(1);
    check("t4_resume", {30'h0, running, halted}, 32'h2);
    check("t4_addr1", {24'h0, i_addr}, 32'h1);
    branch_taken = 1'b0;
    tick(1);
    check("t4_ir1", {16'h0, id_ir}, 32'h7011);

    // 5: PC wrap, enable drop, start ignored while disabled
    branch_taken = 1'b1; branch_addr = 8'hfe;
    tick(1);
    branch_taken = 1'b0;
    tick(2);
    check("t5_wrap", {24'h0, i_addr}, 32'h0);
    check("t5_ir255", {16'h0, id_ir}, 32'h80ef);
    check("t5_pc255", {24'h0, id_pc}, 32'hff);
    tick(2);
    enable = 1'b0;
    tick(1);
    check("t5_idle", {30'h0, running, halted}, 32'h0);
    check("t5_idle_ir", {16'h0, id_ir}, 32'h0);
    check("t5_idle_addr", {24'h0, i_addr}, 32'h2);
    start = 1'b1;
    tick(2);
    check("t5_start_ign", {31'h0, running}, 32'h0);
    check("t5_addr_held", {24'h0, i_addr}, 32'h2);
    enable = 1'b1; start = 1'b0;
    tick(1);
    check("t5_no_start", {31'h0, running}, 32'h0);
    start = 1'b1;
    tick(1);
    check("t5_restart", {31'h0, running}, 32'h1);
    check("t5_restart_pc", {24'h0, i_addr}, 32'h0);
    start = 1'b0;

`ifdef FETCH_PERF_EN
    // 6: performance counters
    check("t6_fetch0", {16'h0, fetch_cnt}, 32'h0);
    check("t6_bubble0", {16'h0, bubble_cnt}, 32'h0);
    tick(10);
    stall = 1'b1;
    tick(3);
    stall = 1'b0;
    check("t6_fetch", {16'h0, fetch_cnt}, 32'd10);
    check("t6_bubble", {16'h0, bubble_cnt}, 32'd3);
    enable = 1'b0;
    tick(1);
    enable = 1'b1; start = 1'b1;
    tick(1);
    start = 1'b0;
    check("t6_fetch_clr", {16'h0, fetch_cnt}, 32'h0);
    check("t6_bubble_clr", {16'h0, bubble_cnt}, 32'h0);
`endif

    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
